// File: rtl/mysystem_note_pkg.sv
// Shared definitions for the note player.
// Holds the playback FSM state encoding, the bit positions of the two fields
// in a 32-bit note word, and the default number of valid RAM words.
package mysystem_note_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LATCH = 2'd2,
    PLAY  = 2'd3
  } state_t;

  // Note word: [31:16] half period in clk cycles (0 = rest),
  //            [15:0]  duration in ticks (0 = end of song)
  localparam int HP_MSB  = 31;
  localparam int HP_LSB  = 16;
  localparam int DUR_MSB = 15;
  localparam int DUR_LSB = 0;

  localparam int DEFAULT_RAM_DEPTH = 3250;

endpackage

// File: rtl/mysystem_note_tone.sv
// Square-wave generator: a half-period divider driving a toggle flop.
// Ports:
//   clk, reset_n  - clock and asynchronous active-low reset
//   enable        - advance the divider this cycle
//   clear         - synchronously return divider and output to 0
//   half_period   - cycles between output toggles (must be nonzero when enabled)
//   tone          - square-wave output, starts low after clear
module mysystem_note_tone (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        clear,
  input  logic [15:0] half_period,
  output logic        tone
);

  logic [15:0] cnt;

  // The output flips after every half_period enabled cycles, so the first
  // toggle happens half_period cycles after the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= 16'd0;
      tone <= 1'b0;
    end else if (clear) begin
      cnt  <= 16'd0;
      tone <= 1'b0;
    end else if (enable) begin
      if (cnt == half_period - 16'd1) begin
        cnt  <= 16'd0;
        tone <= ~tone;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/mysystem_note_player.sv
// Plays a song stored as 32-bit note words in a read-latency-1 RAM.
// Ports:
//   clk, reset_n      - clock and asynchronous active-low reset
//   start, stop       - one-cycle playback request / abort (stop wins)
//   base_addr         - word address of the first note, sampled on start
//   note_count        - number of notes to play, sampled on start
//   ram_address       - word address to the note RAM (valid in FETCH)
//   ram_chipselect    - read strobe to the note RAM
//   ram_readdata      - RAM data, valid the cycle after the strobe
//   buzzer            - square-wave tone output
//   busy              - high whenever not IDLE
//   done              - one-cycle pulse on normal completion
//   addr_err          - sticky out-of-range fetch flag, cleared by start
//   note_index        - index of the note being fetched or played
module mysystem_note_player
  import mysystem_note_pkg::*;
#(
  parameter int TICK_CYCLES = 50000,
  parameter int RAM_DEPTH   = DEFAULT_RAM_DEPTH
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [11:0] base_addr,
  input  logic [11:0] note_count,
  output logic [11:0] ram_address,
  output logic        ram_chipselect,
  input  logic [31:0] ram_readdata,
  output logic        buzzer,
  output logic        busy,
  output logic        done,
  output logic        addr_err,
  output logic [11:0] note_index
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  state_t      state, state_next;
  logic [11:0] base_q, count_q, index_q;
  logic [15:0] half_period_q, duration_q;
  logic [TW-1:0] tick_cnt;
  logic [15:0] tick_num;
  logic        done_q, addr_err_q;
  logic        tone;

  logic [11:0] fetch_addr;
  logic        fetch_ok;
  logic        tick_last;
  logic        play_last;
  logic        last_note;
  logic [15:0] rd_duration;

  // The address wraps at 4096 before the range check, so a wrapped address
  // below RAM_DEPTH is still a legal fetch.
  assign fetch_addr  = base_q + index_q;
  assign fetch_ok    = {20'd0, fetch_addr} < $unsigned(RAM_DEPTH);
  assign tick_last   = (tick_cnt == TW'(TICK_CYCLES - 1));
  assign play_last   = tick_last && (tick_num == duration_q - 16'd1);
  assign last_note   = (index_q + 12'd1 == count_q);
  assign rd_duration = ram_readdata[DUR_MSB:DUR_LSB];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:  if (start && note_count != 12'd0) state_next = FETCH;
        FETCH: state_next = fetch_ok ? LATCH : IDLE;
        LATCH: state_next = (rd_duration == 16'd0) ? IDLE : PLAY;
        PLAY:  if (play_last) state_next = last_note ? IDLE : FETCH;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath: everything here is frozen while stop is asserted so an abort
  // never produces a done pulse or a spurious address error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q        <= 12'd0;
      count_q       <= 12'd0;
      index_q       <= 12'd0;
      half_period_q <= 16'd0;
      duration_q    <= 16'd0;
      tick_cnt      <= '0;
      tick_num      <= 16'd0;
      done_q        <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!stop) begin
        case (state)
          IDLE: begin
            if (start) begin
              base_q     <= base_addr;
              count_q    <= note_count;
              index_q    <= 12'd0;
              addr_err_q <= 1'b0;
              if (note_count == 12'd0) done_q <= 1'b1;
            end
          end
          FETCH: begin
            if (!fetch_ok) addr_err_q <= 1'b1;
          end
          LATCH: begin
            half_period_q <= ram_readdata[HP_MSB:HP_LSB];
            duration_q    <= rd_duration;
            tick_cnt      <= '0;
            tick_num      <= 16'd0;
            if (rd_duration == 16'd0) done_q <= 1'b1;
          end
          PLAY: begin
            if (tick_last) begin
              tick_cnt <= '0;
              tick_num <= tick_num + 16'd1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
            if (play_last) begin
              index_q <= index_q + 12'd1;
              if (last_note) done_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The tone generator is held cleared outside PLAY so every note starts low;
  // a rest simply never enables it.
  mysystem_note_tone u_tone (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (state == PLAY && half_period_q != 16'd0),
    .clear       (state != PLAY),
    .half_period (half_period_q),
    .tone        (tone)
  );

  assign buzzer         = tone && (state == PLAY);
  assign busy           = (state != IDLE);
  assign ram_chipselect = (state == FETCH) && fetch_ok;
  assign ram_address    = (state == FETCH) ? fetch_addr : 12'd0;
  assign done           = done_q;
  assign addr_err       = addr_err_q;
  assign note_index     = index_q;

endmodule

// File: tb/tb_mysystem_note_player.sv
// Directed testbench for mysystem_note_player with a small tick (4 cycles)
// and a latency-1 RAM model. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_mysystem_note_player;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic [11:0] base_addr;
  logic [11:0] note_count;
  logic [11:0] ram_address;
  logic        ram_chipselect;
  logic [31:0] ram_readdata;
  logic        buzzer;
  logic        busy;
  logic        done;
  logic        addr_err;
  logic [11:0] note_index;

  logic [31:0] mem [0:4095];
  int          checks;
  int          errors;
  int          cs_count;
  int          cs_before;
  logic [7:0]  pat_hp3;
  logic [3:0]  pat_hp2;
  logic [3:0]  pat_hp1;

  mysystem_note_player #(
    .TICK_CYCLES (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .stop           (stop),
    .base_addr      (base_addr),
    .note_count     (note_count),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_readdata   (ram_readdata),
    .buzzer         (buzzer),
    .busy           (busy),
    .done           (done),
    .addr_err       (addr_err),
    .note_index     (note_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency-1 RAM; data outside a strobed read is junk so a mistimed capture shows up.
  always @(posedge clk) begin
    ram_readdata <= ram_chipselect ? mem[ram_address] : 32'hFFFF_FFFF;
    if (ram_chipselect) cs_count <= cs_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one cycle of control inputs, then return them to idle.
  task automatic applyStimulus(input logic s, input logic p, input logic [11:0] b, input logic [11:0] c);
    start      = s;
    stop       = p;
    base_addr  = b;
    note_count = c;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    cs_count     = 0;
    ram_readdata = 32'd0;
    reset_n      = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    base_addr    = 12'd0;
    note_count   = 12'd0;
    pat_hp3      = 8'b0011_1000;
    pat_hp2      = 4'b1100;
    pat_hp1      = 4'b1010;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;

    stepCycles(2);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cs", ram_chipselect, 0);
    checkOutput("rst_addr", ram_address, 0);
    checkOutput("rst_buzzer", buzzer, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", addr_err, 0);
    checkOutput("rst_index", note_index, 0);
    reset_n = 1'b1;
    stepCycles(1);

    // Single note, half period 3, two ticks
    $display("[TB] single note");
    mem[0] = 32'h0003_0002;
    cs_before = cs_count;
    applyStimulus(1, 0, 12'd0, 12'd1);
    checkOutput("t1_fetch_cs", ram_chipselect, 1);
    checkOutput("t1_fetch_addr", ram_address, 0);
    checkOutput("t1_fetch_busy", busy, 1);
    stepCycles(1);
    checkOutput("t1_latch_cs", ram_chipselect, 0);
    checkOutput("t1_latch_buz", buzzer, 0);
    stepCycles(1);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("t1_buz%0d", k), buzzer, pat_hp3[k]);
      checkOutput($sformatf("t1_busy%0d", k), busy, 1);
      stepCycles(1);
    end
    checkOutput("t1_done", done, 1);
    checkOutput("t1_idle_busy", busy, 0);
    checkOutput("t1_idle_buz", buzzer, 0);
    checkOutput("t1_reads", cs_count - cs_before, 1);
    stepCycles(1);
    checkOutput("t1_done_pulse", done, 0);

    // Rest followed by a half-period-2 note
    $display("[TB] rest then tone");
    mem[0] = 32'h0000_0001;
    mem[1] = 32'h0002_0001;
    applyStimulus(1, 0, 12'd0, 12'd2);
    checkOutput("t2_fetch0_addr", ram_address, 0);
    stepCycles(2);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t2_rest%0d", k), buzzer, 0);
      checkOutput($sformatf("t2_rest_idx%0d", k), note_index, 0);
      stepCycles(1);
    end
    checkOutput("t2_fetch1_cs", ram_chipselect, 1);
    checkOutput("t2_fetch1_addr", ram_address, 1);
    checkOutput("t2_fetch1_idx", note_index, 1);
    checkOutput("t2_fetch1_done", done, 0);
    stepCycles(2);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t2_buz%0d", k), buzzer, pat_hp2[k]);
      stepCycles(1);
    end
    checkOutput("t2_done", done, 1);
    checkOutput("t2_busy", busy, 0);

    // Zero duration ends the song right after LATCH
    $display("[TB] end-of-song word");
    mem[0] = 32'h0005_0000;
    applyStimulus(1, 0, 12'd0, 12'd3);
    checkOutput("t3_fetch_busy", busy, 1);
    stepCycles(1);
    checkOutput("t3_latch_busy", busy, 1);
    checkOutput("t3_latch_done", done, 0);
    stepCycles(1);
    checkOutput("t3_done", done, 1);
    checkOutput("t3_busy", busy, 0);
    checkOutput("t3_buz", buzzer, 0);

    // Second fetch runs past the end of RAM
    $display("[TB] address range");
    mem[3249] = 32'h0001_0001;
    applyStimulus(1, 0, 12'd3249, 12'd2);
    checkOutput("t4_fetch_addr", ram_address, 3249);
    checkOutput("t4_fetch_cs", ram_chipselect, 1);
    stepCycles(2);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t4_buz%0d", k), buzzer, pat_hp1[k]);
      stepCycles(1);
    end
    checkOutput("t4_bad_addr", ram_address, 3250);
    checkOutput("t4_bad_cs", ram_chipselect, 0);
    checkOutput("t4_bad_idx", note_index, 1);
    stepCycles(1);
    checkOutput("t4_err", addr_err, 1);
    checkOutput("t4_no_done", done, 0);
    checkOutput("t4_busy", busy, 0);
    stepCycles(1);
    checkOutput("t4_err_sticky", addr_err, 1);
    checkOutput("t4_no_done2", done, 0);

    // Stop together with start in mid-play, then replay from base
    $display("[TB] stop and replay");
    mem[0] = 32'h0003_0002;
    applyStimulus(1, 0, 12'd0, 12'd1);
    checkOutput("t5_err_cleared", addr_err, 0);
    stepCycles(2);
    stepCycles(4);
    checkOutput("t5_play_buz", buzzer, 1);
    applyStimulus(1, 1, 12'd5, 12'd7);
    checkOutput("t5_stop_busy", busy, 0);
    checkOutput("t5_stop_buz", buzzer, 0);
    checkOutput("t5_stop_cs", ram_chipselect, 0);
    checkOutput("t5_stop_done", done, 0);
    for (int k = 0; k < 3; k++) begin
      stepCycles(1);
      checkOutput($sformatf("t5_quiet_done%0d", k), done, 0);
      checkOutput($sformatf("t5_quiet_busy%0d", k), busy, 0);
    end
    applyStimulus(1, 0, 12'd0, 12'd1);
    checkOutput("t5_re_cs", ram_chipselect, 1);
    checkOutput("t5_re_addr", ram_address, 0);
    checkOutput("t5_re_idx", note_index, 0);
    stepCycles(2);
    applyStimulus(1, 0, 12'd100, 12'd9);
    checkOutput("t5_ignored_busy", busy, 1);
    stepCycles(6);
    checkOutput("t5_last_busy", busy, 1);
    checkOutput("t5_last_buz", buzzer, 0);
    stepCycles(1);
    checkOutput("t5_re_done", done, 1);
    checkOutput("t5_re_index", note_index, 1);

    // Asynchronous reset mid-play, then an empty song
    $display("[TB] reset mid-play");
    applyStimulus(1, 0, 12'd0, 12'd1);
    stepCycles(6);
    checkOutput("t6_pre_buz", buzzer, 1);
    checkOutput("t6_pre_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_buz", buzzer, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_cs", ram_chipselect, 0);
    checkOutput("t6_rst_addr", ram_address, 0);
    checkOutput("t6_rst_done", done, 0);
    checkOutput("t6_rst_err", addr_err, 0);
    checkOutput("t6_rst_idx", note_index, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cs_before = cs_count;
    applyStimulus(1, 0, 12'd0, 12'd0);
    checkOutput("t6_empty_done", done, 1);
    checkOutput("t6_empty_busy", busy, 0);
    stepCycles(1);
    checkOutput("t6_empty_pulse", done, 0);
    checkOutput("t6_empty_reads", cs_count - cs_before, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mysystem_note_player.md
MYSYSTEM_NOTE_PLAYER -- requirements
Module: mysystem_note_player

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 50000, clk cycles per duration tick (1 ms at 50 MHz).
REQ-002 SHALL have parameter RAM_DEPTH, default 3250, number of valid 32-bit words in the note RAM.
REQ-003 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle request to begin playback.
REQ-006 SHALL have port stop  in  1  one-cycle request to abort playback.
REQ-007 SHALL have port base_addr  in  12  word address of first note; sampled on accepted start.
REQ-008 SHALL have port note_count  in  12  number of notes to play; sampled on accepted start.
REQ-009 SHALL have port ram_address  out  12  word address to the note RAM.
REQ-010 SHALL have port ram_chipselect  out  1  read strobe to the note RAM; write is never driven.
REQ-011 SHALL have port ram_readdata  in  32  RAM data, valid the cycle after ram_chipselect (fixed latency 1).
REQ-012 SHALL have port buzzer  out  1  square-wave tone output.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.
REQ-014 SHALL have port done  out  1  one-cycle pulse on normal completion.
REQ-015 SHALL have port addr_err  out  1  sticky flag; set on an out-of-range fetch, cleared on the next accepted start.
REQ-016 SHALL have port note_index  out  12  index of the note currently fetched or playing.

Function
REQ-017 Note word SHALL be formatted as [31:16] half_period in clk cycles (0 = rest) and [15:0] duration in ticks (0 = end-of-song).
REQ-018 FSM states SHALL be IDLE, FETCH, LATCH, PLAY.
REQ-019 IDLE SHALL accept start when stop is low: latch base_addr and note_count, clear index and addr_err, then go to FETCH; if note_count==0, pulse done next cycle and stay IDLE.
REQ-020 FETCH SHALL last one cycle with ram_chipselect=1 and ram_address=base+index, computed mod 4096.
REQ-021 If base+index >= RAM_DEPTH in FETCH, the block SHALL instead set addr_err, deassert chipselect, and return to IDLE with no done pulse.
REQ-022 LATCH SHALL capture ram_readdata at the end of the cycle; duration==0 SHALL pulse done and go to IDLE; otherwise go to PLAY.
REQ-023 PLAY SHALL last exactly duration*TICK_CYCLES cycles.
REQ-024 In PLAY, buzzer SHALL toggle every half_period cycles starting low; buzzer SHALL be held 0 for a rest.
REQ-025 At PLAY end: index+1; if index+1==note_count, pulse done and go to IDLE with buzzer 0; otherwise go to FETCH.
REQ-026 Stop SHALL force IDLE from any state next cycle with buzzer 0, chipselect 0, and no done pulse; stop SHALL win over a simultaneous start.
REQ-027 Start while busy SHALL be ignored.
REQ-028 Total cycles from accepted start to the first buzzer activity SHALL be 3: IDLE->FETCH->LATCH->PLAY.
REQ-029 Tick and tone counters SHALL be sized for 16-bit fields and TICK_CYCLES without overflow.

Reset
REQ-030 While reset_n is low, state SHALL be IDLE and ram_address, ram_chipselect, buzzer, busy, done, addr_err and note_index SHALL all be 0, asynchronously.
REQ-031 Reset deassertion mid-playback SHALL resume in IDLE; no note data is retained.

Structure
REQ-032 Package mysystem_note_pkg SHALL hold the state enum, note-word field bit positions and the default RAM_DEPTH constant.
REQ-033 Sub-module mysystem_note_tone (half-period divider plus toggle flop, with enable and clear) SHALL generate buzzer.

Verification
REQ-034 Use TICK_CYCLES=4, RAM word 0 = 0x0003_0002, base=0, count=1 -> chipselect in the cycle after start; buzzer toggles every 3 cycles for 8 cycles; done 1 cycle after PLAY ends.
REQ-035 Words 0x0000_0001 (rest), then 0x0002_0001, count=2 -> buzzer 0 for 4 cycles, second fetch at address 1, then toggle every 2 cycles.
REQ-036 Word 0x0005_0000 at index 0, count=3 -> done right after LATCH; no PLAY; busy low.
REQ-037 base=3249, count=2 -> first note plays; second fetch sees address 3250 -> addr_err=1, no chipselect, no done.
REQ-038 Stop asserted mid-PLAY together with start -> IDLE next cycle, buzzer 0, no done; a later start replays from base.
REQ-039 reset_n pulled low mid-PLAY -> all outputs 0 immediately; count=0 start afterwards -> done pulse and no RAM access.
